// File: rtl/ddc_pkg.sv
// Shared constants, FSM state type and ring fill helper for the DDC buffer reader.
package ddc_pkg;

    localparam int DDC_RAM_DEPTH = 11520;
    localparam int DDC_RAM_AW    = 14;
    localparam int DDC_IQ_W      = 32;
    localparam int DDC_OBUF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        WAIT  = 2'd2,
        READ  = 2'd3
    } ddc_rd_state_t;

    // Words available between read and write pointers on the non power-of-two ring.
    function automatic logic [14:0] ddc_fill(input logic [DDC_RAM_AW-1:0] waddr,
                                             input logic [DDC_RAM_AW-1:0] raddr);
        logic [14:0] w_w;
        logic [14:0] w_r;
        w_w = {1'b0, waddr};
        w_r = {1'b0, raddr};
        if (w_w >= w_r) begin
            ddc_fill = w_w - w_r;
        end else begin
            ddc_fill = w_w + 15'(DDC_RAM_DEPTH) - w_r;
        end
    endfunction

endpackage

// File: rtl/ddc_rd_obuf.sv
// 4-deep first-word-fall-through FIFO holding {last, I/Q} words ahead of the stream port.
module ddc_rd_obuf
    import ddc_pkg::*;
#(
    parameter int W = 33
)(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [2:0]   o_count
);

    logic [W-1:0] r_mem [DDC_OBUF_DEPTH];
    logic [1:0]   r_wptr;
    logic [1:0]   r_rptr;
    logic [2:0]   r_count;
    logic         w_do_pop;
    logic         w_do_push;

    assign w_do_pop  = i_pop && (r_count != 3'd0);
    assign w_do_push = i_push && ((r_count != 3'd4) || w_do_pop);
    assign o_head    = r_mem[r_rptr];
    assign o_count   = r_count;

    // Storage, pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
            for (int i = 0; i < DDC_OBUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= r_wptr + 2'd1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ddc_buf_reader.sv
// Streams complete frames out of the DDC ring buffer as AXI-Stream.
// Overrun detection/resync is built only when DDC_BUF_READER_OVF_DET_EN is defined.
module ddc_buf_reader
    import ddc_pkg::*;
#(
    parameter int U_DLY     = 1,
    parameter int FRAME_LEN = 256,
    parameter int RD_LAT    = 2
)(
    input  logic                  lbs_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  ovf_clr,
    input  logic [DDC_RAM_AW-1:0] ddc_conv_waddr,
    output logic [DDC_RAM_AW-1:0] lbs_addr,
    input  logic [DDC_IQ_W-1:0]   ddc_conv_data,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DDC_IQ_W-1:0]   m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  ovf,
    output logic [15:0]           frame_cnt
);

    localparam logic [12:0]           LP_LAST_IDX  = 13'(FRAME_LEN - 1);
    localparam logic [14:0]           LP_FRAME_LEN = 15'(FRAME_LEN);
    localparam logic [DDC_RAM_AW-1:0] LP_RADDR_MAX = 14'(DDC_RAM_DEPTH - 1);

    generate
        if (FRAME_LEN < 1 || FRAME_LEN > 5760 || RD_LAT < 1 || RD_LAT > 3 || U_DLY < 0) begin : g_bad_cfg
            logic w_bad_cfg_unused;
            assign w_bad_cfg_unused = 1'b1;
        end
    endgenerate

    ddc_rd_state_t         r_state;
    ddc_rd_state_t         w_state_nxt;
    logic [DDC_RAM_AW-1:0] r_raddr;
    logic [12:0]           r_widx;
    logic [RD_LAT-1:0]     r_vld_pipe;
    logic [RD_LAT-1:0]     r_last_pipe;
    logic [15:0]           r_frame_cnt;
    logic [14:0]           w_fill;
    logic [2:0]            w_outstanding;
    logic [2:0]            w_buf_count;
    logic [DDC_IQ_W:0]     w_head;
    logic                  w_issue;
    logic                  w_ovr;
    logic                  w_pop;

    assign w_fill = ddc_fill(ddc_conv_waddr, r_raddr);

`ifdef DDC_BUF_READER_OVF_DET_EN
    localparam logic [14:0] LP_OVR_FILL = 15'(DDC_RAM_DEPTH - FRAME_LEN);
    logic r_ovf;

    assign w_ovr = (r_state == WAIT) && enable && (w_fill >= LP_OVR_FILL);
    assign ovf   = r_ovf;

    // Sticky overrun flag; a new overrun beats a clear in the same cycle.
    always_ff @(posedge lbs_clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_ovr) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end
`else
    logic w_unused_ovf_clr;
    assign w_unused_ovf_clr = ovf_clr;
    assign w_ovr = 1'b0;
    assign ovf   = 1'b0;
`endif

    // Reads in flight plus buffered words are capped at the buffer depth.
    always_comb begin
        w_outstanding = 3'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_outstanding = w_outstanding + {2'b00, r_vld_pipe[i]};
        end
        w_issue = (r_state == READ) &&
                  (({1'b0, w_outstanding} + {1'b0, w_buf_count}) < 4'd4);
    end

    // Next-state logic; READ ignores enable so frames are never cut short.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (enable) w_state_nxt = ALIGN;
                else        w_state_nxt = IDLE;
            end
            ALIGN: w_state_nxt = WAIT;
            WAIT: begin
                if (!enable)                    w_state_nxt = IDLE;
                else if (w_ovr)                 w_state_nxt = WAIT;
                else if (w_fill >= LP_FRAME_LEN) w_state_nxt = READ;
                else                            w_state_nxt = WAIT;
            end
            READ: begin
                if (w_issue && (r_widx == LP_LAST_IDX)) w_state_nxt = WAIT;
                else                                    w_state_nxt = READ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge lbs_clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Read pointer: snaps to the writer on align or resync, otherwise advances per read.
    always_ff @(posedge lbs_clk) begin
        if (rst) begin
            r_raddr <= '0;
            r_widx  <= 13'd0;
        end else begin
            if ((r_state == ALIGN) || w_ovr) begin
                r_raddr <= ddc_conv_waddr;
            end else if (w_issue) begin
                r_raddr <= (r_raddr == LP_RADDR_MAX) ? '0 : r_raddr + 14'd1;
            end
            if (w_issue) begin
                r_widx <= (r_widx == LP_LAST_IDX) ? 13'd0 : r_widx + 13'd1;
            end
        end
    end

    // Tracks issued reads and their last tag until the RAM data returns.
    always_ff @(posedge lbs_clk) begin
        if (rst) begin
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
        end else begin
            r_vld_pipe[0]  <= w_issue;
            r_last_pipe[0] <= w_issue && (r_widx == LP_LAST_IDX);
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_last_pipe[i] <= r_last_pipe[i-1];
            end
        end
    end

    ddc_rd_obuf #(.W(DDC_IQ_W + 1)) u_obuf (
        .i_clk   (lbs_clk),
        .i_rst   (rst),
        .i_push  (r_vld_pipe[RD_LAT-1]),
        .i_din   ({r_last_pipe[RD_LAT-1], ddc_conv_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_buf_count)
    );

    assign m_axis_tvalid = (w_buf_count != 3'd0);
    assign m_axis_tdata  = w_head[DDC_IQ_W-1:0];
    assign m_axis_tlast  = w_head[DDC_IQ_W];
    assign w_pop         = m_axis_tvalid && m_axis_tready;

    // Completed frames counter.
    always_ff @(posedge lbs_clk) begin
        if (rst) begin
            r_frame_cnt <= 16'd0;
        end else if (w_pop && w_head[DDC_IQ_W]) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign lbs_addr  = r_raddr;
    assign busy      = (r_state != IDLE) || (w_buf_count != 3'd0) || (r_vld_pipe != '0);

endmodule

// File: tb/tb_ddc_buf_reader.sv
// Scoreboard bench for ddc_buf_reader (FRAME_LEN=8, RD_LAT=2); RAM word at address a is {a, ~a}.
module tb_ddc_buf_reader;

    localparam int FL    = 8;
    localparam int DEPTH = 11520;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        ovf_clr;
    logic [13:0] waddr;
    logic [13:0] lbs_addr;
    logic [31:0] rdata;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tlast;
    logic        busy;
    logic        ovf;
    logic [15:0] frame_cnt;

    logic [13:0] ram_a1;
    logic [13:0] ram_a2;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [32:0] sb[$];
    bit          sb_ignore = 1'b0;

    ddc_buf_reader #(.U_DLY(1), .FRAME_LEN(FL), .RD_LAT(2)) u_dut (
        .lbs_clk        (clk),
        .rst            (rst),
        .enable         (enable),
        .ovf_clr        (ovf_clr),
        .ddc_conv_waddr (waddr),
        .lbs_addr       (lbs_addr),
        .ddc_conv_data  (rdata),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tdata   (tdata),
        .m_axis_tlast   (tlast),
        .busy           (busy),
        .ovf            (ovf),
        .frame_cnt      (frame_cnt)
    );

    always #5 clk = ~clk;

    // Two-cycle read latency RAM model.
    always @(posedge clk) begin
        ram_a1 <= lbs_addr;
        ram_a2 <= ram_a1;
    end
    assign rdata = {{2'b00, ram_a2}, ~{2'b00, ram_a2}};

    function automatic logic [32:0] beat(input int a, input bit last);
        logic [15:0] v;
        v = a[15:0];
        return {last, v, ~v};
    endfunction

    task automatic push_frames(input int start, input int nwords);
        for (int i = 0; i < nwords; i++) begin
            sb.push_back(beat((start + i) % DEPTH, (i % FL) == FL - 1));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mon_loop();
        bit          prev_stall;
        logic [32:0] prev_beat;
        logic [32:0] exp;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (sb_ignore) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    n_total++;
                    if (tvalid !== 1'b1 || {tlast, tdata} !== prev_beat) begin
                        n_bad++;
                        $display("FAIL hold_stable: got v=%b %h, need v=1 %h", tvalid, {tlast, tdata}, prev_beat);
                    end
                end
                if (tvalid === 1'b1 && tready === 1'b1) begin
                    n_total++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_beat: got %h, need none", {tlast, tdata});
                    end else begin
                        exp = sb.pop_front();
                        if ({tlast, tdata} !== exp) begin
                            n_bad++;
                            $display("FAIL beat: got %h, need %h", {tlast, tdata}, exp);
                        end
                    end
                end
                prev_stall = (tvalid === 1'b1) && (tready !== 1'b1);
                prev_beat  = {tlast, tdata};
            end
        end
    endtask

    task automatic wait_drain(input int limit);
        int c;
        c = 0;
        while (sb.size() != 0 && c < limit) begin
            @(posedge clk);
            c++;
        end
        n_total++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending, need 0", sb.size());
        end
        @(negedge clk);
    endtask

    task automatic check_frames(input int exp_frames);
        n_total++;
        if (frame_cnt !== 16'(exp_frames)) begin
            n_bad++;
            $display("FAIL frame_cnt: got %0d, need %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; ovf_clr = 1'b0; waddr = 14'd0; tready = 1'b1;
        tick(3);
        @(negedge clk);
        n_total += 6;
        if (lbs_addr !== 14'd0) begin n_bad++; $display("FAIL rst_addr: got %0d, need 0", lbs_addr); end
        if (tvalid !== 1'b0)    begin n_bad++; $display("FAIL rst_tvalid: got %b, need 0", tvalid); end
        if ({tlast, tdata} !== 33'd0) begin n_bad++; $display("FAIL rst_data: got %h, need 0", {tlast, tdata}); end
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b, need 0", busy); end
        if (ovf !== 1'b0)       begin n_bad++; $display("FAIL rst_ovf: got %b, need 0", ovf); end
        if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_frames: got %0d, need 0", frame_cnt); end
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic_frame();
        enable = 1'b1;
        tick(2);
        waddr = 14'd8;
        push_frames(0, 8);
        @(negedge clk);
        n_total += 2;
        if (tvalid !== 1'b0) begin n_bad++; $display("FAIL early_tvalid: got %b, need 0", tvalid); end
        if (busy !== 1'b1)   begin n_bad++; $display("FAIL busy_wait: got %b, need 1", busy); end
        tick(1); @(negedge clk);
        n_total++;
        if (lbs_addr !== 14'd0) begin n_bad++; $display("FAIL first_addr: got %0d, need 0", lbs_addr); end
        tick(1); @(negedge clk);
        n_total++;
        if (lbs_addr !== 14'd1) begin n_bad++; $display("FAIL second_addr: got %0d, need 1", lbs_addr); end
        tick(1); @(negedge clk);
        n_total++;
        if (tvalid !== 1'b0) begin n_bad++; $display("FAIL latency_early: got %b, need 0", tvalid); end
        tick(1); @(negedge clk);
        n_total++;
        if (tvalid !== 1'b1) begin n_bad++; $display("FAIL latency: got %b, need 1", tvalid); end
        wait_drain(40);
        check_frames(1);
    endtask

    task automatic test_wrap();
        int c;
        enable = 1'b0;
        waddr  = 14'd11516;
        tick(2);
        enable = 1'b1;
        tick(3);
        waddr = 14'd4;
        push_frames(11516, 8);
        c = 0;
        @(negedge clk);
        while (tvalid !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (tvalid !== 1'b1) begin n_bad++; $display("FAIL wrap_gap: beat %0d got v=%b, need 1", i, tvalid); end
            @(negedge clk);
        end
        wait_drain(40);
        check_frames(2);
    endtask

    task automatic test_backpressure();
        int i;
        waddr = 14'd68;
        push_frames(4, 64);
        i = 0;
        while (i < 600) begin
            @(posedge clk); #1;
            if (sb.size() == 0) break;
            tready = ((i % 4) == 0) || ((i % 4) == 3);
            i++;
        end
        tready = 1'b1;
        wait_drain(20);
        check_frames(10);
    endtask

    task automatic test_overrun();
        // fill = 60 + 11520 - 68 = 11512 = DEPTH - FRAME_LEN
`ifdef DDC_BUF_READER_OVF_DET_EN
        waddr = 14'd60;
        tick(1); @(negedge clk);
        n_total += 2;
        if (ovf !== 1'b1)        begin n_bad++; $display("FAIL ovf_set: got %b, need 1", ovf); end
        if (lbs_addr !== 14'd60) begin n_bad++; $display("FAIL ovf_resync: got %0d, need 60", lbs_addr); end
        tick(8); @(negedge clk);
        n_total += 2;
        if (ovf !== 1'b1)    begin n_bad++; $display("FAIL ovf_sticky: got %b, need 1", ovf); end
        if (tvalid !== 1'b0) begin n_bad++; $display("FAIL ovf_no_beat: got %b, need 0", tvalid); end
        tick(1); ovf_clr = 1'b1;
        tick(1); ovf_clr = 1'b0;
        @(negedge clk);
        n_total++;
        if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clr: got %b, need 0", ovf); end
`else
        sb_ignore = 1'b1;
        waddr = 14'd60;
        tick(1); @(negedge clk);
        n_total++;
        if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_off: got %b, need 0", ovf); end
        tick(1); ovf_clr = 1'b1;
        tick(1); ovf_clr = 1'b0;
        @(negedge clk);
        n_total++;
        if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_off_clr: got %b, need 0", ovf); end
`endif
        tick(1);
        enable = 1'b0;
        rst    = 1'b1;
        tick(1);
        rst = 1'b0;
        sb.delete();
        sb_ignore = 1'b0;
        waddr = 14'd0;
        tick(2); @(negedge clk);
        check_frames(0);
        n_total++;
        if (tvalid !== 1'b0) begin n_bad++; $display("FAIL post_rst_tvalid: got %b, need 0", tvalid); end
    endtask

    task automatic test_stop_midframe();
        int c;
        tick(1);
        enable = 1'b1;
        tick(3);
        waddr = 14'd8;
        push_frames(0, 8);
        c = 0;
        @(negedge clk);
        while (lbs_addr !== 14'd3 && c < 20) begin
            @(negedge clk);
            c++;
        end
        n_total++;
        if (lbs_addr !== 14'd3) begin n_bad++; $display("FAIL stop_addr3: got %0d, need 3", lbs_addr); end
        tick(1);
        enable = 1'b0;
        wait_drain(40);
        check_frames(1);
        tick(4); @(negedge clk);
        n_total += 2;
        if (busy !== 1'b0)   begin n_bad++; $display("FAIL stop_busy: got %b, need 0", busy); end
        if (tvalid !== 1'b0) begin n_bad++; $display("FAIL stop_tvalid: got %b, need 0", tvalid); end
    endtask

    task automatic test_reset_in_read();
        tick(1);
        tready = 1'b0;
        enable = 1'b1;
        tick(3);
        waddr = 14'd16;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst    = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        n_total += 3;
        if (tvalid !== 1'b0)    begin n_bad++; $display("FAIL rr_tvalid: got %b, need 0", tvalid); end
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL rr_busy: got %b, need 0", busy); end
        if (lbs_addr !== 14'd0) begin n_bad++; $display("FAIL rr_addr: got %0d, need 0", lbs_addr); end
        tick(1);
        tready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_total++;
            if (tvalid !== 1'b0) begin n_bad++; $display("FAIL rr_stale: cycle %0d got v=%b, need 0", i, tvalid); end
        end
    endtask

    initial begin
        fork
            mon_loop();
        join_none
        test_reset();
        test_basic_frame();
        test_wrap();
        test_backpressure();
        test_overrun();
        test_stop_midframe();
        test_reset_in_read();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ddc_buf_reader.md
# ddc_buf_reader

Reader for the DDC sample ring buffer: tracks the write pointer `ddc_conv_waddr` published by the DDC stage, fetches complete frames of packed I/Q words (`{I[15:0],Q[15:0]}`) through the RAM read port (`lbs_addr`/`ddc_conv_data`), and streams them out as AXI-Stream with `tlast` per frame. It sits on the `lbs_clk` side of the DDC, between the 11520-word ring buffer and the downstream packetiser/DMA. It also detects writer overrun and resynchronises to the write pointer.

## Interface
- `U_DLY`, 1: simulation delay on non-blocking assignments.
- `FRAME_LEN`, 256: words per output frame; legal range 1..5760.
- `RD_LAT`, 2: RAM read latency, in cycles from `lbs_addr` to valid `ddc_conv_data`; legal range 1..3.
- `lbs_clk`  in  1  single clock; all logic is in this domain.
- `rst`  in  1  reset, synchronous and active-high.
- `enable`  in  1  run request; level-sensitive.
- `ovf_clr`  in  1  one-cycle pulse; clears sticky `ovf`.
- `ddc_conv_waddr`  in  14  next write address of the DDC, already synchronised to `lbs_clk`; range 0..11519.
- `lbs_addr`  out  14  RAM read address.
- `ddc_conv_data`  in  32  RAM read data.
- `m_axis_tvalid`  out  1  output stream valid.
- `m_axis_tready`  in  1  output stream ready.
- `m_axis_tdata`  out  32  `{I,Q}` word.
- `m_axis_tlast`  out  1  asserted on the last word of each frame.
- `busy`  out  1  high whenever the state is not IDLE or the output buffer is non-empty.
- `ovf`  out  1  sticky overrun flag.
- `frame_cnt`  out  16  count of completed frames, i.e. frames whose `tlast` beat has been accepted; wraps at 65535.

## Operation
- Ring depth is `DEPTH = 11520`.
- Fill level: `fill = (waddr >= raddr) ? waddr - raddr : waddr + DEPTH - raddr`. Computed in 15 bits; result is 0..11519.
- `raddr` increments by 1 per issued read and wraps from 11519 to 0. `lbs_addr` is driven by `raddr`.
- FSM states and transitions:
  - IDLE: leave when `enable` = 1, go to ALIGN.
  - ALIGN: set `raddr` <= `ddc_conv_waddr`; go to WAIT.
  - WAIT:
    - If `enable` = 0, go to IDLE. Any in-flight data still drains from the output buffer.
    - Else if overrun condition is met, set `ovf`, set `raddr` <= `ddc_conv_waddr`, and stay in WAIT.
    - Else if `fill >= FRAME_LEN`, go to READ.
  - READ: issue exactly `FRAME_LEN` reads, then go to WAIT. `enable` is not sampled in READ, so a frame is never truncated.
- Overrun condition: `fill >= DEPTH - FRAME_LEN`. It is evaluated only in WAIT.
- Read issue rule: a read is issued in a cycle only if `outstanding + buf_count < 4`, where the output buffer is 4 deep. This guarantees the buffer never overflows under backpressure.
- Returned data is pushed into the buffer `RD_LAT` cycles after issue, together with a `last` tag. The tag is set when the frame word index equals `FRAME_LEN-1`.
- `m_axis_tdata`, `m_axis_tlast` and `m_axis_tvalid` come from the head of the buffer. A beat transfers when `m_axis_tvalid & m_axis_tready`.
- A simultaneous push and pop leaves `buf_count` unchanged.
- `ovf_clr` together with a new overrun in the same cycle: the set wins.
- `frame_cnt` increments on an accepted `tlast` beat.
- Reset mid-operation: all state returns to reset values on the next edge. The buffer and the outstanding pipeline are flushed, and in-flight RAM data is discarded.

## Timing
- Reset values: `lbs_addr` = 0, `m_axis_tvalid` = 0, `m_axis_tdata` = 0, `m_axis_tlast` = 0, `busy` = 0, `ovf` = 0, `frame_cnt` = 0. FSM is in IDLE.
- `enable` rising to the first read: IDLE at cycle N, ALIGN at N+1, WAIT at N+2, first `lbs_addr` issued at N+3 if the fill check passes.
- Read address to `m_axis_tvalid` is `RD_LAT + 1` cycles.
- With `tready` held high, throughput is 1 word per cycle.
- When `tready` goes low, at most 4 beats are buffered and issue stalls within 1 cycle.
- `m_axis_tdata` and `m_axis_tlast` are held stable while `tvalid & ~tready`.

## Configuration
- Macro: `DDC_BUF_READER_OVF_DET_EN`.
- Defined: overrun detection, resync and the sticky `ovf` flag operate as described above.
- Undefined: no overrun check is made, `ovf` is tied to 0, and `ovf_clr` is ignored. WAIT then only compares `fill` against `FRAME_LEN`.

## Structure
- Shared package `ddc_pkg`:
  - `DDC_RAM_DEPTH = 11520`
  - `DDC_RAM_AW = 14`
  - `DDC_IQ_W = 32`
  - FSM state enum `ddc_rd_state_t` with states IDLE, ALIGN, WAIT, READ.
- Sub-module `ddc_rd_obuf`: 4-deep, 33-bit (data + last) synchronous FIFO with `count`, `push`, `pop`, and first-word-fall-through head. It is instantiated once.

## Test plan
- Basic frame: `FRAME_LEN` = 8, `RD_LAT` = 2. Write pointer moves from 0 to 8 with RAM word k = `{k, ~k}`. Expect 8 beats of `{k, ~k}` with `tlast` on word 7, and `frame_cnt` = 1.
- Wrap-around: set `waddr` = 11516 at `enable`, then advance it to 4. Expect addresses 11516..11519, 0..3, then `tlast`, with no gap when `tready` = 1.
- Backpressure: toggle `tready` with pattern 1,0,0,1 over 64 words. Expect every word exactly once and in order, and `buf_count` never above 4.
- Overrun: `FRAME_LEN` = 256. Jump `waddr` so that `fill` = 11264. Expect `ovf` = 1, `raddr` = `waddr`, no beat output, and `ovf` still 1 until `ovf_clr`. With the macro undefined, expect `ovf` = 0.
- Stop mid-frame: drop `enable` at word 3 of 8. Expect the full frame including `tlast`, then IDLE and `busy` = 0.
- Reset in READ: assert `rst` for 1 cycle with 3 reads outstanding. Expect `m_axis_tvalid` = 0 on the next cycle and no stale beats afterwards.
